audio_stereo_in: RTL and testbench
==================================

// Module: audio_stereo_in
// PURPOSE
//  Capture side of the stereo audio path. Takes two 1-bit delta-sigma/PWM bitstreams
//  (external comparator or ADC modulator) and decimates each one with a windowed
//  ones-count into an 8-bit PCM sample. Emits packed {left,right} PCM with a rdy/ack
//  handshake, in the same format that audio_stereo_out consumes. Sits in clk_audio.
// PARAMETERS
//  PCM_WIDTH  8    bits per channel sample
//  WINDOW     255  clk_audio cycles per sample window; must be in 1 .. 2**PCM_WIDTH-1
//  SYNC_STAGES 2   flip-flop synchronizer depth on each bitstream input (>=2)
// PORTS
//  clk_audio       in   1            sole clock
//  aclr            in   1            asynchronous reset, active-high
//  left            in   1            left bitstream, asynchronous to clk_audio
//  right           in   1            right bitstream, asynchronous to clk_audio
//  stereo_pcm      out  2*PCM_WIDTH  {left_sample, right_sample}, left in MSBs
//  stereo_pcm_rdy  out  1            sample valid; held until accepted
//  stereo_pcm_ack  in   1            consumer accepts sample when rdy&ack at clock edge
//  overrun         out  1            sticky: an unaccepted sample was overwritten
//  overrun_clr     in   1            synchronous clear of overrun
// BEHAVIOUR
//  - Reset (aclr=1, async): sync chains=0, window counter=0, accumulators=0,
//    stereo_pcm=0, stereo_pcm_rdy=0, overrun=0. Mid-operation reset discards the
//    partial window and any pending sample; counting restarts on the first edge after release.
//  - Input path: each bitstream passes through SYNC_STAGES flops; only the synced bit is used.
//  - Window counter wcnt runs 0..WINDOW-1 and wraps to 0; it always runs (no enable).
//  - Each cycle: acc_x <= acc_x + synced_x. When wcnt==WINDOW-1 (the "dump" cycle):
//    sample_x = acc_x + synced_x is loaded into stereo_pcm at that edge, and acc_x <= 0.
//    Result range 0..WINDOW, fits PCM_WIDTH bits; no saturation logic needed.
//  - Latency: a pin change reaches the accumulator after SYNC_STAGES cycles. After
//    reset, the first window therefore contains SYNC_STAGES zero bits.
//  - Handshake (all at one clock edge):
//    dump & !rdy           -> load, rdy<=1
//    dump & rdy & ack      -> load, rdy stays 1, no overrun
//    dump & rdy & !ack     -> load (overwrite), rdy stays 1, overrun<=1
//    !dump & rdy & ack     -> rdy<=0, stereo_pcm holds its value
//  - With ack tied 1, rdy is a 1-cycle pulse every WINDOW cycles. This is the streaming mode.
//  - overrun_clr clears overrun. If overrun_clr and a new overrun event happen in the
//    same cycle, the set wins.
//  - stereo_pcm changes only on a dump edge. It is stable whenever rdy=1 and no dump occurs.
// STRUCTURE
//  - Shared package audio_pkg: PCM_WIDTH default, DEFAULT_WINDOW=255, localparams for
//    stereo packing (LEFT_MSB/LEFT_LSB/RIGHT_MSB/RIGHT_LSB). This packing is shared with
//    audio_stereo_out.
//  - Sub-module audio_bitstream_accum, instantiated twice (left and right). It contains
//    the sync chain and the accumulator, takes the dump strobe as an input, and outputs
//    the finished sample.
//  - Top level holds wcnt, the output register, the rdy/ack control and the overrun flag.
// TESTING
//  1 left=1, right=0 constant, ack=1 -> first rdy pulse at cycle WINDOW-1 after reset with
//    {253,0}; later pulses every 255 cycles with {255,0}.
//  2 left alternating 1/0 every cycle, right=1 constant, ack=1 -> left sample 127 or 128
//    (depends on phase), right 255; repeats each window.
//  3 Both bitstreams 0, ack=1 -> {0,0} every window; overrun stays 0.
//  4 ack=0 for 3 windows, then ack=1 -> rdy rises at first dump and stays high; overrun=1
//    after second dump; stereo_pcm holds the 3rd sample. overrun_clr pulse -> overrun=0.
//  5 ack asserted on the same edge as a dump -> new sample loaded, rdy stays 1, overrun=0.
//  6 aclr pulse at wcnt=100 -> all outputs 0 immediately; next rdy comes WINDOW cycles
//    after release, with the first-window value (e.g. 253 for constant 1s).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path constants: default sample width, decimation window and the
// {left,right} stereo packing used by both audio_stereo_in and audio_stereo_out.
package audio_pkg;

   localparam int DEFAULT_PCM_WIDTH   = 8;
   localparam int DEFAULT_WINDOW      = 255;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Left channel occupies the upper half of the packed stereo word
   localparam int LEFT_MSB  = 2*DEFAULT_PCM_WIDTH - 1;
   localparam int LEFT_LSB  = DEFAULT_PCM_WIDTH;
   localparam int RIGHT_MSB = DEFAULT_PCM_WIDTH - 1;
   localparam int RIGHT_LSB = 0;

   typedef struct packed {
      logic [DEFAULT_PCM_WIDTH-1:0] left;
      logic [DEFAULT_PCM_WIDTH-1:0] right;
   } stereo_sample_t;

endpackage

// File: rtl/audio_bitstream_accum.sv
// One channel of the capture path: synchronizes an asynchronous 1-bit stream and
// counts its ones over a window; the window boundary is strobed in by the parent.
module audio_bitstream_accum
   import audio_pkg::*;
#(
   parameter int PCM_WIDTH   = DEFAULT_PCM_WIDTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                 clk_audio,
   input  logic                 aclr,
   input  logic                 bit_in,
   input  logic                 dump,
   output logic [PCM_WIDTH-1:0] sample
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [PCM_WIDTH-1:0]   acc_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // Finished sample includes the bit arriving on the dump cycle itself
   assign sample = acc_q + PCM_WIDTH'(synced);

   // NOTE: the synchronizer flops are reset too, so a mid-operation reset cannot
   // leak stale pin history into the first window after release.
   always_ff @(posedge clk_audio or posedge aclr) begin
      if (aclr) begin
         sync_q <= '0;
         acc_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bit_in};
         acc_q  <= dump ? '0 : sample;
      end
   end

endmodule

// File: rtl/audio_stereo_in.sv
// Stereo bitstream capture: windowed ones-count decimation of two 1-bit streams
// into packed {left,right} PCM, offered to the consumer with a rdy/ack handshake.
module audio_stereo_in
   import audio_pkg::*;
#(
   parameter int PCM_WIDTH   = DEFAULT_PCM_WIDTH,
   parameter int WINDOW      = DEFAULT_WINDOW,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                   clk_audio,
   input  logic                   aclr,
   input  logic                   left,
   input  logic                   right,
   output logic [2*PCM_WIDTH-1:0] stereo_pcm,
   output logic                   stereo_pcm_rdy,
   input  logic                   stereo_pcm_ack,
   output logic                   overrun,
   input  logic                   overrun_clr
);

   localparam logic [PCM_WIDTH-1:0] WCNT_LAST = PCM_WIDTH'(WINDOW - 1);

   logic [PCM_WIDTH-1:0] wcnt;
   logic [PCM_WIDTH-1:0] sample_l;
   logic [PCM_WIDTH-1:0] sample_r;
   logic                 dump;
   logic                 ov_set;

   assign dump   = (wcnt == WCNT_LAST);
   assign ov_set = dump & stereo_pcm_rdy & ~stereo_pcm_ack;

   audio_bitstream_accum #(
      .PCM_WIDTH   (PCM_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_accum_l (
      .clk_audio (clk_audio),
      .aclr      (aclr),
      .bit_in    (left),
      .dump      (dump),
      .sample    (sample_l)
   );

   audio_bitstream_accum #(
      .PCM_WIDTH   (PCM_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_accum_r (
      .clk_audio (clk_audio),
      .aclr      (aclr),
      .bit_in    (right),
      .dump      (dump),
      .sample    (sample_r)
   );

   // NOTE: all state updates use non-blocking assignments so every register sees
   // the pre-edge values of wcnt, rdy and ack, regardless of statement order.
   always_ff @(posedge clk_audio or posedge aclr) begin
      if (aclr) begin
         wcnt <= '0;
      end else begin
         wcnt <= dump ? '0 : wcnt + PCM_WIDTH'(1);
      end
   end

   // A dump always loads and always leaves rdy set; ack without a dump retires it
   always_ff @(posedge clk_audio or posedge aclr) begin
      if (aclr) begin
         stereo_pcm     <= '0;
         stereo_pcm_rdy <= 1'b0;
      end else if (dump) begin
         stereo_pcm     <= {sample_l, sample_r};
         stereo_pcm_rdy <= 1'b1;
      end else if (stereo_pcm_rdy && stereo_pcm_ack) begin
         stereo_pcm_rdy <= 1'b0;
      end
   end

   // Set has priority over clear so a simultaneous overwrite is never lost
   always_ff @(posedge clk_audio or posedge aclr) begin
      if (aclr) begin
         overrun <= 1'b0;
      end else if (ov_set) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_stereo_in.sv
// Self-checking bench for audio_stereo_in: directed scenarios plus random streams,
// compared cycle by cycle against a behavioural window/handshake model.
module tb_audio_stereo_in;
   import audio_pkg::*;

   localparam int PW = DEFAULT_PCM_WIDTH;
   localparam int W  = DEFAULT_WINDOW;
   localparam int SS = DEFAULT_SYNC_STAGES;

   logic            clk_audio = 1'b0;
   logic            aclr;
   logic            left;
   logic            right;
   logic [2*PW-1:0] stereo_pcm;
   logic            stereo_pcm_rdy;
   logic            stereo_pcm_ack;
   logic            overrun;
   logic            overrun_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk_audio = ~clk_audio;

   audio_stereo_in #(
      .PCM_WIDTH   (PW),
      .WINDOW      (W),
      .SYNC_STAGES (SS)
   ) dut (
      .clk_audio      (clk_audio),
      .aclr           (aclr),
      .left           (left),
      .right          (right),
      .stereo_pcm     (stereo_pcm),
      .stereo_pcm_rdy (stereo_pcm_rdy),
      .stereo_pcm_ack (stereo_pcm_ack),
      .overrun        (overrun),
      .overrun_clr    (overrun_clr)
   );

   // Reference model: pin history delayed by SS edges, ones counted per window
   bit              pipe_l[$];
   bit              pipe_r[$];
   int              ones_l, ones_r;
   int              pos;
   logic [2*PW-1:0] m_pcm;
   bit              m_rdy;
   bit              m_ov;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pipe_l = {};
      pipe_r = {};
      for (int i = 0; i < SS; i++) begin
         pipe_l.push_back(1'b0);
         pipe_r.push_back(1'b0);
      end
      ones_l = 0;
      ones_r = 0;
      pos    = 0;
      m_pcm  = '0;
      m_rdy  = 1'b0;
      m_ov   = 1'b0;
   endtask

   task automatic model_edge();
      bit s_l, s_r, ov_evt;
      logic [PW-1:0] v_l, v_r;
      s_l = pipe_l.pop_front();
      s_r = pipe_r.pop_front();
      pipe_l.push_back(left);
      pipe_r.push_back(right);
      ones_l += int'(s_l);
      ones_r += int'(s_r);
      ov_evt = 1'b0;
      if (pos == W - 1) begin
         v_l    = PW'(ones_l);
         v_r    = PW'(ones_r);
         m_pcm  = {v_l, v_r};
         ov_evt = m_rdy && !stereo_pcm_ack;
         m_rdy  = 1'b1;
         ones_l = 0;
         ones_r = 0;
      end else if (m_rdy && stereo_pcm_ack) begin
         m_rdy = 1'b0;
      end
      if (ov_evt)
         m_ov = 1'b1;
      else if (overrun_clr)
         m_ov = 1'b0;
      pos = (pos + 1) % W;
   endtask

   task automatic step();
      @(posedge clk_audio);
      model_edge();
      #1;
      check("pcm", 32'(stereo_pcm), 32'(m_pcm));
      check("rdy", 32'(stereo_pcm_rdy), 32'(m_rdy));
      check("ovr", 32'(overrun), 32'(m_ov));
   endtask

   // mode 0: L=1 R=0, 1: L toggles R=1, 2: both 0, 3: random
   task automatic run(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         case (mode)
            0: begin left = 1'b1;  right = 1'b0; end
            1: begin left = ~left; right = 1'b1; end
            2: begin left = 1'b0;  right = 1'b0; end
            default: begin left = 1'($urandom); right = 1'($urandom); end
         endcase
         step();
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_pcm"}, 32'(stereo_pcm), 32'd0);
      check({tag, "_rdy"}, 32'(stereo_pcm_rdy), 32'd0);
      check({tag, "_ovr"}, 32'(overrun), 32'd0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk_audio);
      @(negedge clk_audio);
      aclr = 1'b0;
   endtask

   task automatic run_to_dump(input int mode);
      for (int i = 0; i < W && pos != W - 1; i++)
         run(1, mode);
   endtask

   initial begin
      aclr           = 1'b1;
      left           = 1'b0;
      right          = 1'b0;
      stereo_pcm_ack = 1'b1;
      overrun_clr    = 1'b0;
      model_reset();
      #1;
      check_cleared("reset");
      release_reset();

      // 1: constant L=1, R=0 streaming
      run(W, 0);
      check("t1_first_rdy", 32'(stereo_pcm_rdy), 32'd1);
      check("t1_first_l", 32'(stereo_pcm[LEFT_MSB:LEFT_LSB]), 32'(W - SS));
      check("t1_first_r", 32'(stereo_pcm[RIGHT_MSB:RIGHT_LSB]), 32'd0);
      run(1, 0);
      check("t1_pulse_end", 32'(stereo_pcm_rdy), 32'd0);
      run(W - 1, 0);
      check("t1_full_l", 32'(stereo_pcm[LEFT_MSB:LEFT_LSB]), 32'(W));

      // 2: alternating left, constant right
      run(2*W, 1);
      check("t2_r", 32'(stereo_pcm[RIGHT_MSB:RIGHT_LSB]), 32'(W));
      check("t2_l_half", 32'(stereo_pcm[LEFT_MSB:LEFT_LSB] == 8'd127 ||
                             stereo_pcm[LEFT_MSB:LEFT_LSB] == 8'd128), 32'd1);

      // 3: silence
      run(2*W, 2);
      check("t3_zero", 32'(stereo_pcm), 32'd0);
      check("t3_ovr", 32'(overrun), 32'd0);

      // 4: consumer stalls for three windows
      stereo_pcm_ack = 1'b0;
      run(2*W, 3);
      check("t4_ovr_set", 32'(overrun), 32'd1);
      check("t4_rdy_held", 32'(stereo_pcm_rdy), 32'd1);
      run(W, 3);
      stereo_pcm_ack = 1'b1;
      run(1, 3);
      check("t4_rdy_drop", 32'(stereo_pcm_rdy), 32'd0);
      overrun_clr = 1'b1;
      run(1, 3);
      overrun_clr = 1'b0;
      check("t4_ovr_clr", 32'(overrun), 32'd0);

      // 5: ack lands on the dump edge itself
      stereo_pcm_ack = 1'b0;
      run_to_dump(3);
      run(1, 3);
      run_to_dump(3);
      stereo_pcm_ack = 1'b1;
      run(1, 3);
      check("t5_rdy", 32'(stereo_pcm_rdy), 32'd1);
      check("t5_ovr", 32'(overrun), 32'd0);

      // overrun set and clear in the same cycle: set wins
      stereo_pcm_ack = 1'b0;
      run_to_dump(3);
      overrun_clr = 1'b1;
      run(1, 3);
      overrun_clr = 1'b0;
      check("set_wins", 32'(overrun), 32'd1);

      // 6: reset in mid-window
      stereo_pcm_ack = 1'b1;
      run(W, 3);
      aclr = 1'b1;
      model_reset();
      release_reset();
      run(100, 0);
      aclr = 1'b1;
      #1;
      model_reset();
      check_cleared("t6_reset");
      release_reset();
      run(W - 1, 0);
      check("t6_no_early_rdy", 32'(stereo_pcm_rdy), 32'd0);
      run(1, 0);
      check("t6_rdy", 32'(stereo_pcm_rdy), 32'd1);
      check("t6_l", 32'(stereo_pcm[LEFT_MSB:LEFT_LSB]), 32'(W - SS));

      // random streams with random back-pressure and clears
      for (int i = 0; i < 20*W; i++) begin
         stereo_pcm_ack = ($urandom_range(0, 3) != 0);
         overrun_clr    = ($urandom_range(0, 31) == 0);
         run(1, 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
